// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register map, bit positions and defaults for the UART receive controller
package uart_pkg;

   // Register addresses on the CPU bus
   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_STAT = 2'd1;
   localparam logic [1:0] ADDR_BRGL = 2'd2;
   localparam logic [1:0] ADDR_BRGH = 2'd3;

   // STATUS bit positions
   localparam int ST_AVAIL  = 0;
   localparam int ST_FULL   = 1;
   localparam int ST_OVR    = 2;
   localparam int ST_IRQEN  = 3;

   // CTRL bit positions
   localparam int CTRL_IRQEN = 0;
   localparam int CTRL_FLUSH = 1;

   // Baud divisor after reset
   localparam logic [15:0] BRG_RST_DEF = 16'd26;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous byte FIFO with push, pop, flush and occupancy count
module uart_rx_fifo #(
   parameter int AW = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic [7:0]    wdata_i,
   input  logic          pop_i,
   input  logic          flush_i,
   output logic [7:0]    rdata_o,
   output logic          full_o,
   output logic          empty_o,
   output logic          overflow_o,
   output logic [AW:0]   count_o,
   output logic [AW:0]   count_next_o
);

   localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};

   logic [7:0]    mem_q [2**AW];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          push_ok, pop_ok;

   assign full_o  = (count_q == DEPTH_C);
   assign empty_o = (count_q == '0);
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign count_next_o = count_d;

   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
   assign pop_ok     = pop_i & ~empty_o & ~flush_i;
   assign push_ok    = push_i & (~full_o | pop_ok) & ~flush_i;
   assign overflow_o = push_i & full_o & ~pop_ok & ~flush_i;

   // Next pointer and occupancy values; flush wins over everything
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
         else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
      end
   end

   // Pointer and count registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array, no reset so it maps onto RAM
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - CPU register front end, baud generator and receive FIFO for the UART receiver
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int          FIFO_AW = 4,
   parameter logic [15:0] BRG_RST = BRG_RST_DEF
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       cs_i,
   input  logic [1:0] addr_i,
   input  logic       we_i,
   input  logic       re_i,
   input  logic [7:0] data_i,
   output logic [7:0] data_o,
   output logic       irq_o,
   output logic       brg_stb_o,
   input  logic       rx_done_stb_i,
   input  logic [7:0] rx_data_i
);

   logic [15:0] brg_q, brg_d;
   logic [15:0] brg_cnt_q, brg_cnt_d;
   logic        brg_stb_q, brg_stb_d;
   logic [7:0]  data_q, data_d;
   logic        irq_q, irq_d;
   logic        ovr_q, ovr_d;
   logic        irq_en_q, irq_en_d;

   logic          rd, wr, brg_wr, pop, flush;
   logic [7:0]    fifo_head;
   logic          fifo_full, fifo_empty, fifo_overflow;
   logic [FIFO_AW:0] fifo_count, fifo_count_next;
   logic [7:0]    status;

   assign rd     = cs_i & re_i;
   assign wr     = cs_i & we_i;
   assign brg_wr = wr & ((addr_i == ADDR_BRGL) | (addr_i == ADDR_BRGH));
   assign pop    = rd & (addr_i == ADDR_DATA) & ~fifo_empty;
   assign flush  = wr & (addr_i == ADDR_STAT) & data_i[CTRL_FLUSH];

   assign status = {4'b0000, irq_en_q, ovr_q, fifo_full, (fifo_count != '0)};

   uart_rx_fifo #(
      .AW (FIFO_AW)
   ) u_fifo (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .push_i       (rx_done_stb_i),
      .wdata_i      (rx_data_i),
      .pop_i        (pop),
      .flush_i      (flush),
      .rdata_o      (fifo_head),
      .full_o       (fifo_full),
      .empty_o      (fifo_empty),
      .overflow_o   (fifo_overflow),
      .count_o      (fifo_count),
      .count_next_o (fifo_count_next)
   );

   // Baud generator: divisor writes restart the count from the new full value
   always_comb begin
      brg_d     = brg_q;
      brg_cnt_d = brg_cnt_q;
      brg_stb_d = 1'b0;
      if (wr && addr_i == ADDR_BRGL) brg_d[7:0]  = data_i;
      if (wr && addr_i == ADDR_BRGH) brg_d[15:8] = data_i;
      if (brg_wr) begin
         brg_cnt_d = brg_d;
      end else if (brg_cnt_q == 16'd0) begin
         brg_cnt_d = brg_q;
         brg_stb_d = 1'b1;
      end else begin
         brg_cnt_d = brg_cnt_q - 16'd1;
      end
   end

   // Read mux, control bits, sticky overrun and interrupt on next-state values
   always_comb begin
      data_d   = data_q;
      irq_en_d = irq_en_q;
      ovr_d    = ovr_q;
      if (rd) begin
         unique case (addr_i)
            ADDR_DATA: data_d = pop ? fifo_head : 8'h00;
            ADDR_STAT: data_d = status;
            ADDR_BRGL: data_d = brg_q[7:0];
            ADDR_BRGH: data_d = brg_q[15:8];
            default:   data_d = 8'h00;
         endcase
      end
      if (wr && addr_i == ADDR_STAT) irq_en_d = data_i[CTRL_IRQEN];
      if (rd && addr_i == ADDR_STAT) ovr_d = 1'b0;
      if (fifo_overflow)             ovr_d = 1'b1;
      irq_d = irq_en_d & ((fifo_count_next != '0) | ovr_d);
   end

   // Controller state registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         brg_q     <= BRG_RST;
         brg_cnt_q <= BRG_RST;
         brg_stb_q <= 1'b0;
         data_q    <= 8'h00;
         irq_q     <= 1'b0;
         ovr_q     <= 1'b0;
         irq_en_q  <= 1'b0;
      end else begin
         brg_q     <= brg_d;
         brg_cnt_q <= brg_cnt_d;
         brg_stb_q <= brg_stb_d;
         data_q    <= data_d;
         irq_q     <= irq_d;
         ovr_q     <= ovr_d;
         irq_en_q  <= irq_en_d;
      end
   end

   assign data_o    = data_q;
   assign irq_o     = irq_q;
   assign brg_stb_o = brg_stb_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cs, we, re;
   logic [1:0] addr;
   logic [7:0] din;
   logic [7:0] dout;
   logic       irq, stb;
   logic       rx_stb;
   logic [7:0] rx_data;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [7:0]  mq[$];
   logic        m_ovr, m_ien;
   logic [15:0] m_brg;

   // Scoreboard queues
   logic [7:0] exp_rd_q[$];
   logic       exp_irq_q[$];
   logic       mon_en = 1'b0;
   logic       mon_rd;

   always #5 clk = ~clk;

   uart_rx_ctrl #(.FIFO_AW(4), .BRG_RST(16'd26)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .cs_i          (cs),
      .addr_i        (addr),
      .we_i          (we),
      .re_i          (re),
      .data_i        (din),
      .data_o        (dout),
      .irq_o         (irq),
      .brg_stb_o     (stb),
      .rx_done_stb_i (rx_stb),
      .rx_data_i     (rx_data)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_ovr = 1'b0;
      m_ien = 1'b0;
      m_brg = 16'd26;
   endtask

   task automatic set_idle();
      cs = 0; we = 0; re = 0; addr = 0; din = 0; rx_stb = 0; rx_data = 0;
   endtask

   // One bus cycle: drive, predict from the model, then let the edge happen
   task automatic cycle(input logic c, input logic w, input logic r, input logic [1:0] a,
                        input logic [7:0] d, input logic rx, input logic [7:0] rxd);
      logic popped, flush, drop;
      logic [7:0] rv;
      @(negedge clk);
      cs = c; we = w; re = r; addr = a; din = d; rx_stb = rx; rx_data = rxd;
      if (c && r) begin
         case (a)
            2'd0: rv = (mq.size() > 0) ? mq[0] : 8'h00;
            2'd1: rv = {4'b0, m_ien, m_ovr, (mq.size() == 16), (mq.size() > 0)};
            2'd2: rv = m_brg[7:0];
            default: rv = m_brg[15:8];
         endcase
         exp_rd_q.push_back(rv);
      end
      popped = c && r && a == 2'd0 && mq.size() > 0;
      flush  = c && w && a == 2'd1 && d[1];
      drop   = 1'b0;
      if (popped) void'(mq.pop_front());
      if (flush) mq.delete();
      else if (rx) begin
         if (mq.size() < 16) mq.push_back(rxd);
         else drop = 1'b1;
      end
      if (c && r && a == 2'd1) m_ovr = 1'b0;
      if (drop) m_ovr = 1'b1;
      if (c && w && a == 2'd1) m_ien = d[0];
      if (c && w && a == 2'd2) m_brg[7:0] = d;
      if (c && w && a == 2'd3) m_brg[15:8] = d;
      exp_irq_q.push_back(m_ien && (mq.size() > 0 || m_ovr));
      @(posedge clk);
      #1 set_idle();
   endtask

   task automatic idle();     cycle(0, 0, 0, 2'd0, 8'h00, 0, 8'h00); endtask
   task automatic push(input logic [7:0] b); cycle(0, 0, 0, 2'd0, 8'h00, 1, b); endtask
   task automatic rd(input logic [1:0] a);   cycle(1, 0, 1, a, 8'h00, 0, 8'h00); endtask
   task automatic wr(input logic [1:0] a, input logic [7:0] d); cycle(1, 1, 0, a, d, 0, 8'h00); endtask

   // Monitor: compares every read result and the interrupt level after each edge
   always @(posedge clk) begin
      mon_rd = cs & re;
      #2;
      if (mon_en) begin
         if (mon_rd) begin
            if (exp_rd_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL rd_unexpected: got %h expected none", dout);
            end else check("data_o", {8'h00, dout}, {8'h00, exp_rd_q.pop_front()});
         end
         if (exp_irq_q.size() > 0) check("irq_o", {15'd0, irq}, {15'd0, exp_irq_q.pop_front()});
      end
   end

   // Measure the strobe period over n idle cycles
   task automatic brg_period(input string name, input int n, input int period);
      int last, seen;
      last = -1; seen = 0;
      for (int i = 0; i < n; i++) begin
         idle();
         #1;
         if (stb === 1'b1) begin
            if (last >= 0) check(name, 16'(i - last), 16'(period));
            last = i;
            seen++;
         end
      end
      check({name, "_seen"}, {15'd0, seen >= 2}, 16'd1);
   endtask

   initial begin
      set_idle();
      rst = 1'b1;
      model_reset();
      #1;
      check("rst_data_o", {8'h00, dout}, 16'h0000);
      check("rst_irq_o", {15'd0, irq}, 16'h0000);
      check("rst_brg_stb_o", {15'd0, stb}, 16'h0000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      mon_en = 1'b1;

      // Baud generator period after reset, then with divisor 3
      brg_period("brg_period_rst", 90, 27);
      wr(2'd3, 8'h00);
      wr(2'd2, 8'h03);
      brg_period("brg_period_3", 20, 4);
      rd(2'd2);
      rd(2'd3);

      // Two bytes in, read back in order
      push(8'hA5); push(8'h3C);
      rd(2'd1); rd(2'd0); rd(2'd0); rd(2'd0); rd(2'd1);

      // Overflow by one byte
      for (int i = 1; i <= 17; i++) push(8'(i));
      rd(2'd1); rd(2'd1);
      for (int i = 0; i < 17; i++) rd(2'd0);

      // Full FIFO with simultaneous push and pop
      for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
      cycle(1, 0, 1, 2'd0, 8'h00, 1, 8'hEE);
      rd(2'd1);
      for (int i = 0; i < 17; i++) rd(2'd0);

      // Empty FIFO with simultaneous push and pop
      cycle(1, 0, 1, 2'd0, 8'h00, 1, 8'h77);
      rd(2'd0);

      // Interrupt behaviour, flush keeps overrun
      wr(2'd1, 8'h01);
      push(8'h11);
      idle();
      rd(2'd0);
      for (int i = 0; i < 17; i++) push(8'(8'h80 + i));
      cycle(1, 1, 0, 2'd1, 8'h03, 1, 8'h99);
      idle();
      rd(2'd1);
      rd(2'd1);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic c, w, r, rx;
         logic [1:0] a;
         logic [7:0] d;
         c  = ($urandom_range(0, 9) < 7);
         r  = $urandom_range(0, 1);
         w  = ~r & ($urandom_range(0, 3) == 0);
         a  = 2'($urandom_range(0, 3));
         d  = 8'($urandom);
         if (a == 2'd1 && w && $urandom_range(0, 3) != 0) d[1] = 1'b0;
         rx = ($urandom_range(0, 9) < 5);
         cycle(c, w, r, a, d, rx, 8'($urandom));
      end

      // Asynchronous reset with bytes queued
      wr(2'd1, 8'h00);
      for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
      wr(2'd1, 8'h01);
      rd(2'd1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_data_o", {8'h00, dout}, 16'h0000);
      check("arst_irq_o", {15'd0, irq}, 16'h0000);
      check("arst_brg_stb_o", {15'd0, stb}, 16'h0000);
      #1 rst = 1'b0;
      model_reset();
      rd(2'd1); rd(2'd2); rd(2'd3); rd(2'd0);
      push(8'h5A);
      rd(2'd0);
      rd(2'd1);

      repeat (3) idle();
      check("scoreboard_drained", 16'(exp_rd_q.size()), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
